apb_rr_arbiter: RTL and testbench

- Shares the single APB master interface to the UART and GPIO slaves between NUM_REQ independent command sources.
- Each requester presents a complete transaction: address, direction and write data.
- The block picks one requester round-robin, runs a standard APB SETUP/ACCESS transfer, and returns read data plus a completion strobe to the winner.
- It replaces per-source ad-hoc master logic; the sole owner of PSEL/PENABLE/PADDR/PWRITE/PWDATA.

---
 rtl/apb_rr_arbiter_if.sv | 37 +++
 rtl/apb_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of requester-side and APB-side signals for apb_rr_arbiter.
// The master modport is the arbiter's view: it is the APB master and answers
// the requesters. The slave modport is the view of the surrounding logic.
interface apb_rr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_err;
    logic [NUM_REQ-1:0]        gnt;

    logic                      PSEL;
    logic                      PENABLE;
    logic [ADDR_W-1:0]         PADDR;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ack, req_rdata, req_err, gnt,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ack, req_rdata, req_err, gnt,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Each granted request runs IDLE -> SETUP -> ACCESS; completion strobes
// req_ack to the winner and moves the priority pointer past it.
// Optional feature macro: APB_TIMEOUT_EN -- adds an ACCESS wait-state limit of
// TIMEOUT_CYC cycles that ends a stalled transfer with req_err=1.
module apb_rr_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_rr_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_param
            $error("apb_rr_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
        end
    endgenerate

    state_t             state_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [NUM_REQ-1:0] gnt_reg;
    logic               psel_reg;
    logic               penable_reg;
    logic               pwrite_reg;
    logic [ADDR_W-1:0]  paddr_reg;
    logic [DATA_W-1:0]  pwdata_reg;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    logic               pick_found_next;
    logic [IDX_W-1:0]   pick_idx_next;
    logic [IDX_W-1:0]   cand_idx;
    logic               timeout_hit;
    logic               done;

    // Modular increment of a requester index, wrapping NUM_REQ-1 -> 0.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_W'(sum);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Pick the first valid requester scanning upward from the pointer.
    always_comb begin
        pick_found_next = 1'b0;
        pick_idx_next   = '0;
        cand_idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = wrap_add(ptr_reg, k);
            if (!pick_found_next && bus.req_valid[cand_idx]) begin
                pick_found_next = 1'b1;
                pick_idx_next   = cand_idx;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;

    // The counter has already counted TIMEOUT_CYC-1 stalled cycles when this fires.
    assign timeout_hit = (state_reg == ACCESS) && !bus.PREADY
                         && (wait_cnt_reg == 8'(TIMEOUT_CYC - 1));
    assign bus.req_err = done && !bus.PREADY;
`else
    assign timeout_hit = 1'b0;
    assign bus.req_err = 1'b0;
`endif

    // A completion (normal or timed out) is signalled in the same ACCESS cycle.
    assign done          = (state_reg == ACCESS) && (bus.PREADY || timeout_hit);
    assign bus.req_ack   = done ? gnt_reg : '0;
    assign bus.req_rdata = (done && bus.PREADY && !pwrite_reg) ? bus.PRDATA : '0;

    assign bus.gnt     = gnt_reg;
    assign bus.PSEL    = psel_reg;
    assign bus.PENABLE = penable_reg;
    assign bus.PADDR   = paddr_reg;
    assign bus.PWRITE  = pwrite_reg;
    assign bus.PWDATA  = pwdata_reg;

    // Transfer FSM with registered APB outputs, grant and round-robin pointer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            idx_reg      <= '0;
            gnt_reg      <= '0;
            psel_reg     <= 1'b0;
            penable_reg  <= 1'b0;
            pwrite_reg   <= 1'b0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    psel_reg    <= 1'b0;
                    penable_reg <= 1'b0;
                    if (pick_found_next) begin
                        state_reg  <= SETUP;
                        psel_reg   <= 1'b1;
                        idx_reg    <= pick_idx_next;
                        gnt_reg    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_next;
                        paddr_reg  <= addr_arr[pick_idx_next];
                        pwrite_reg <= bus.req_write[pick_idx_next];
                        // Reads never expose a stale write payload on PWDATA.
                        pwdata_reg <= bus.req_write[pick_idx_next] ? wdata_arr[pick_idx_next] : '0;
                    end
                end
                SETUP: begin
                    state_reg    <= ACCESS;
                    penable_reg  <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                ACCESS: begin
                    if (done) begin
                        state_reg   <= IDLE;
                        psel_reg    <= 1'b0;
                        penable_reg <= 1'b0;
                        gnt_reg     <= '0;
                        ptr_reg     <= wrap_add(idx_reg, 1);
                    end
`ifdef APB_TIMEOUT_EN
                    else if (!bus.PREADY) begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
`endif
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter. A transaction-level timeline model
// decides each grant and its completion cycle; expectations go into queues
// that a negedge monitor pops whenever the DUT shows a SETUP or a req_ack.
module tb_apb_rr_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef APB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    apb_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int            cyc;
        logic [N-1:0]  gnt;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
    } setup_t;

    typedef struct {
        int            cyc;
        logic [N-1:0]  ack;
        logic [DW-1:0] rdata;
        logic          err;
    } ack_t;

    setup_t setup_q[$];
    ack_t   ack_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // requester-side state owned by the stimulus
    logic [N-1:0]  valid_m = '0;
    logic [N-1:0]  write_m = '0;
    logic [AW-1:0] addr_m  [N];
    logic [DW-1:0] wdata_m [N];

    // timeline model
    bit            busy = 1'b0;
    int            owner = 0;
    int            ptr = 0;
    int            setup_cyc = 0;
    int            ready_cyc = 0;
    int            ack_cyc = 0;
    logic [DW-1:0] rdata_m = '0;

    // knobs
    int            forced_wait = -1;
    bit            forced_rdata_en = 1'b0;
    logic [DW-1:0] forced_rdata = '0;
    bit            auto_reload = 1'b0;
    int            p_new = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic load_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        valid_m[i] = 1'b1;
        write_m[i] = wr;
        addr_m[i]  = a;
        wdata_m[i] = d;
    endtask

    task automatic load_rand(input int i);
        load_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic drive_req();
        bus.req_valid = valid_m;
        bus.req_write = write_m;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW]  = addr_m[i];
            bus.req_wdata[i*DW +: DW] = wdata_m[i];
        end
    endtask

    // Advance one clock: update requesters, let the model arbitrate, drive the slave.
    task automatic step(input bit rst);
        int     w;
        setup_t s;
        ack_t   a;
        @(posedge PCLK);
        #1;
        cyc++;
        PRESET = rst;
        if (busy && cyc == ack_cyc + 1) begin
            valid_m[owner] = 1'b0;
            busy = 1'b0;
            if (auto_reload) load_rand(owner);
        end
        if (rst) begin
            if (busy) begin
                while (ack_q.size() != 0 && ack_q[ack_q.size()-1].cyc >= cyc) void'(ack_q.pop_back());
                while (setup_q.size() != 0 && setup_q[setup_q.size()-1].cyc > cyc) void'(setup_q.pop_back());
            end
            busy = 1'b0;
            ptr  = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (!valid_m[i] && $urandom_range(0, 99) < p_new) load_rand(i);
        end
        if (!rst && !busy && valid_m != '0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (valid_m[(ptr + k) % N]) owner = (ptr + k) % N;
            end
            w         = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 5));
            setup_cyc = cyc + 1;
            ready_cyc = setup_cyc + 1 + w;
            rdata_m   = forced_rdata_en ? forced_rdata : $urandom;
            s.cyc   = setup_cyc;
            s.gnt   = '0;
            s.gnt[owner] = 1'b1;
            s.addr  = addr_m[owner];
            s.wr    = write_m[owner];
            s.wdata = write_m[owner] ? wdata_m[owner] : '0;
            a.ack   = s.gnt;
            if (TO_EN && (w + 1 > TO)) begin
                ack_cyc = setup_cyc + TO;
                a.err   = 1'b1;
                a.rdata = '0;
            end else begin
                ack_cyc = ready_cyc;
                a.err   = 1'b0;
                a.rdata = write_m[owner] ? '0 : rdata_m;
            end
            a.cyc = ack_cyc;
            setup_q.push_back(s);
            ack_q.push_back(a);
            ptr  = (owner + 1) % N;
            busy = 1'b1;
        end
        if (busy && cyc > setup_cyc) begin
            bus.PREADY = (cyc == ready_cyc);
            bus.PRDATA = (cyc == ready_cyc) ? rdata_m : $urandom;
        end else begin
            bus.PREADY = 1'($urandom_range(0, 1));
            bus.PRDATA = $urandom;
        end
        if (rst) bus.PREADY = 1'b0;
        drive_req();
    endtask

    task automatic run_until_idle(input int limit);
        int n;
        n = 0;
        do begin
            step(1'b0);
            n++;
        end while ((busy || valid_m != '0) && n < limit);
        if (busy || valid_m != '0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_bound cyc=%0d got=busy expected=idle", cyc);
        end
    endtask

    // Monitor: pops expectations when the DUT presents SETUP or req_ack.
    setup_t cur_s;
    bit     prst_q = 1'b1;
    always @(negedge PCLK) begin
        setup_t s;
        ack_t   a;
        if (cyc >= 2) begin
            while (setup_q.size() != 0 && setup_q[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missing_setup cyc=%0d got=none expected_at=%0d", cyc, setup_q[0].cyc);
                void'(setup_q.pop_front());
            end
            while (ack_q.size() != 0 && ack_q[0].cyc < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missing_ack cyc=%0d got=none expected_at=%0d", cyc, ack_q[0].cyc);
                void'(ack_q.pop_front());
            end
            if (prst_q) begin
                chk("rst_ctrl", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.req_err, bus.gnt, bus.req_ack}, '0);
                chk("rst_paddr", bus.PADDR, '0);
                chk("rst_data", {bus.PWDATA, bus.req_rdata}, '0);
            end
            chk("gnt_onehot0", $onehot0(bus.gnt), 1);
            chk("ack_onehot0", $onehot0(bus.req_ack), 1);
            if (!bus.PSEL) begin
                chk("idle_quiet", {bus.PENABLE, bus.gnt, bus.req_ack}, '0);
            end else if (!bus.PENABLE) begin
                if (setup_q.size() != 0 && setup_q[0].cyc == cyc) begin
                    s = setup_q.pop_front();
                    chk("setup_gnt", bus.gnt, s.gnt);
                    chk("setup_paddr", bus.PADDR, s.addr);
                    chk("setup_pwrite", bus.PWRITE, s.wr);
                    chk("setup_pwdata", bus.PWDATA, s.wdata);
                    chk("setup_noack", bus.req_ack, '0);
                    cur_s = s;
                end else begin
                    chk("unexpected_setup", bus.PSEL, 0);
                end
            end else begin
                chk("access_hold", {bus.gnt, bus.PADDR, bus.PWRITE, bus.PWDATA},
                    {cur_s.gnt, cur_s.addr, cur_s.wr, cur_s.wdata});
            end
            if (bus.req_ack != '0) begin
                if (ack_q.size() != 0 && ack_q[0].cyc == cyc) begin
                    a = ack_q.pop_front();
                    chk("ack_vec", bus.req_ack, a.ack);
                    chk("ack_rdata", bus.req_rdata, a.rdata);
                    chk("ack_err", bus.req_err, a.err);
                    chk("ack_in_access", {bus.PSEL, bus.PENABLE}, 2'b11);
                    $display("txn cyc=%0d ack=%b addr=%h wr=%0d rdata=%h err=%0d",
                             cyc, bus.req_ack, bus.PADDR, bus.PWRITE, bus.req_rdata, bus.req_err);
                end else begin
                    chk("unexpected_ack", bus.req_ack, '0);
                end
            end
        end
        prst_q = PRESET;
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            addr_m[i]  = '0;
            wdata_m[i] = '0;
        end
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
        drive_req();
        repeat (3) step(1'b1);

        // single read, zero wait states
        forced_wait     = 0;
        forced_rdata_en = 1'b1;
        forced_rdata    = 32'hA5A5_0001;
        load_req(0, 1'b0, 32'h32, 32'h0);
        run_until_idle(50);

        // write from requester 1 with 3 wait states
        forced_wait = 3;
        load_req(1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        run_until_idle(50);

        // contention: two requesters continuously valid
        forced_wait     = 0;
        forced_rdata_en = 1'b0;
        auto_reload     = 1'b1;
        load_rand(0);
        load_rand(1);
        repeat (11) step(1'b0);
        auto_reload = 1'b0;
        run_until_idle(50);

        // reset during the 2nd wait state of requester 1; pointer returns to 0
        load_req(0, 1'b0, 32'h40, 32'h0);
        run_until_idle(50);
        forced_wait = 10;
        load_req(1, 1'b0, 32'h44, 32'h0);
        repeat (3) step(1'b0);
        load_req(0, 1'b1, 32'h48, 32'h1234_5678);
        step(1'b1);
        forced_wait = 0;
        run_until_idle(50);

        // long stall: times out when enabled, otherwise waits 120 cycles
        forced_wait = 120;
        load_rand(0);
        load_rand(1);
        run_until_idle(600);

        // PREADY arrives exactly on the last permitted ACCESS cycle
        forced_wait     = TO - 1;
        forced_rdata_en = 1'b1;
        forced_rdata    = 32'h5EED_0042;
        load_req(2, 1'b0, 32'h7C, 32'h0);
        run_until_idle(50);

        // randomized traffic with occasional resets
        forced_wait     = -1;
        forced_rdata_en = 1'b0;
        p_new           = 30;
        for (int t = 0; t < 3000; t++) begin
            step(($urandom_range(0, 299) == 0) && !(busy && ack_cyc == cyc + 1));
        end
        p_new = 0;
        run_until_idle(300);
        repeat (4) step(1'b0);

        if (setup_q.size() != 0 || ack_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL queue_drain got=%0d/%0d expected=0/0", setup_q.size(), ack_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
